// File: rtl/normalise_sum_iter_pkg.sv
// Shared encodings for the iterative sum normaliser: FSM states, idle codes,
// datapath widths and the default exponent floor.
package normalise_sum_iter_pkg;

  localparam int SUM_W = 28;
  localparam int LZC_W = 5;
  localparam int EXP_MIN_DEFAULT = -126;

  localparam logic [1:0] NO_IDLE     = 2'b00;
  localparam logic [1:0] ALLIGN_IDLE = 2'b01;
  localparam logic [1:0] PUT_IDLE    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_NORM = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/normalise_sum_iter_norm_lzc.sv
// Combinational leading-zero count of the 27-bit sum below the carry bit;
// a zero input reports 27.
module norm_lzc
  import normalise_sum_iter_pkg::*;
(
  input  logic [SUM_W-2:0] i_sum,
  output logic [LZC_W-1:0] o_lzc
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_lzc = 5'd27;
    for (int i = 0; i < SUM_W - 1; i++) begin
      if (i_sum[i]) o_lzc = 5'(SUM_W - 2 - i);
    end
  end

endmodule

// File: rtl/normalise_sum_iter.sv
// Iterative normaliser between the CORDIC adder and PackSum. Optional macro
// NORM_STICKY_EN keeps the bit lost on a right shift as a sticky bit in sum[0].
module normalise_sum_iter
  import normalise_sum_iter_pkg::*;
#(
  parameter int MAX_LSHIFT = 4,
  parameter int EXP_MIN    = EXP_MIN_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  idle_AddState,
  input  logic [31:0] sout_AddState,
  input  logic [1:0]  modeout_AddState,
  input  logic        operationout_AddState,
  input  logic        NatLogFlagout_AddState,
  input  logic [27:0] sum_AddState,
  input  logic [7:0]  InsTag_AddState,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  idle_NormaliseSum,
  output logic [31:0] sout_NormaliseSum,
  output logic [1:0]  modeout_NormaliseSum,
  output logic        operationout_NormaliseSum,
  output logic        NatLogFlagout_NormaliseSum,
  output logic [7:0]  InsTag_NormaliseSum,
  output logic [27:0] sum_NormaliseSum
);

  localparam logic signed [9:0] EXP_MIN_W = 10'(EXP_MIN);
  localparam logic signed [9:0] EXP_MAX_W = 10'sd127;
  localparam logic signed [9:0] EXP_LO_W  = -10'sd128;

  function automatic logic [7:0] sat_exp8(input logic signed [9:0] e);
    if (e > EXP_MAX_W)     sat_exp8 = 8'h7f;
    else if (e < EXP_LO_W) sat_exp8 = 8'h80;
    else                   sat_exp8 = e[7:0];
  endfunction

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idle, w_idle_nxt;
  logic [31:0] r_sout, w_sout_nxt;
  logic [1:0]  r_mode, w_mode_nxt;
  logic        r_op, w_op_nxt;
  logic        r_natlog, w_natlog_nxt;
  logic [7:0]  r_tag, w_tag_nxt;
  logic [27:0] r_sum, w_sum_nxt;

  logic signed [9:0] w_exp;
  logic signed [9:0] w_exp_shl;
  logic [9:0]        w_room;
  logic [4:0]        w_lzc;
  logic [4:0]        w_n;
  logic [27:0]       w_sum_shl;
  logic [27:0]       w_sum_shr;

  assign w_exp  = {{2{r_sout[30]}}, r_sout[30:23]};
  assign w_room = 10'(w_exp - EXP_MIN_W);

  norm_lzc u_lzc (
    .i_sum (r_sum[26:0]),
    .o_lzc (w_lzc)
  );

  // Shift amount: bounded by leading zeros, per-cycle shifter width and exponent headroom.
  always_comb begin
    w_n = w_lzc;
    if (w_n > 5'(MAX_LSHIFT)) w_n = 5'(MAX_LSHIFT);
    if ({5'b0, w_n} > w_room)  w_n = w_room[4:0];
  end

  assign w_sum_shl = r_sum << w_n;
  assign w_exp_shl = w_exp - $signed({5'b0, w_n});

`ifdef NORM_STICKY_EN
  assign w_sum_shr = {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
`else
  assign w_sum_shr = {1'b0, r_sum[27:1]};
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_idle_nxt   = r_idle;
    w_sout_nxt   = r_sout;
    w_mode_nxt   = r_mode;
    w_op_nxt     = r_op;
    w_natlog_nxt = r_natlog;
    w_tag_nxt    = r_tag;
    w_sum_nxt    = r_sum;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_idle_nxt   = idle_AddState;
          w_sout_nxt   = sout_AddState;
          w_mode_nxt   = modeout_AddState;
          w_op_nxt     = operationout_AddState;
          w_natlog_nxt = NatLogFlagout_AddState;
          w_tag_nxt    = InsTag_AddState;
          w_sum_nxt    = sum_AddState;
          w_state_nxt  = ST_NORM;
        end
      end
      ST_NORM: begin
        if (r_idle == PUT_IDLE) begin
          w_state_nxt = ST_DONE;
        end else if (r_sum[27]) begin
          w_sum_nxt          = w_sum_shr;
          w_sout_nxt[30:23]  = sat_exp8(w_exp + 10'sd1);
          w_state_nxt        = ST_DONE;
        end else if (r_sum == '0) begin
          w_sout_nxt[30:23]  = sat_exp8(EXP_MIN_W);
          w_state_nxt        = ST_DONE;
        end else if (r_sum[26] || (w_exp <= EXP_MIN_W)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_sum_nxt         = w_sum_shl;
          w_sout_nxt[30:23] = sat_exp8(w_exp_shl);
          // Finish in the same cycle the shift lands on the hidden bit or the floor.
          if (w_sum_shl[26] || (w_exp_shl <= EXP_MIN_W)) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idle   <= '0;
      r_sout   <= '0;
      r_mode   <= '0;
      r_op     <= 1'b0;
      r_natlog <= 1'b0;
      r_tag    <= '0;
      r_sum    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idle   <= w_idle_nxt;
      r_sout   <= w_sout_nxt;
      r_mode   <= w_mode_nxt;
      r_op     <= w_op_nxt;
      r_natlog <= w_natlog_nxt;
      r_tag    <= w_tag_nxt;
      r_sum    <= w_sum_nxt;
    end
  end

  assign in_ready                   = (r_state == ST_IDLE) && !reset;
  assign out_valid                  = (r_state == ST_DONE);
  assign idle_NormaliseSum          = r_idle;
  assign sout_NormaliseSum          = r_sout;
  assign modeout_NormaliseSum       = r_mode;
  assign operationout_NormaliseSum  = r_op;
  assign NatLogFlagout_NormaliseSum = r_natlog;
  assign InsTag_NormaliseSum        = r_tag;
  assign sum_NormaliseSum           = r_sum;

endmodule

// File: tb/tb_normalise_sum_iter.sv
// Self-checking bench for normalise_sum_iter: directed corner cases, reset
// behaviour and randomized operands against an arithmetic reference model.
module tb_normalise_sum_iter;

  localparam int MAXL = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  idle_in;
  logic [31:0] sout_in;
  logic [1:0]  mode_in;
  logic        op_in;
  logic        nat_in;
  logic [27:0] sum_in;
  logic [7:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  idle_o;
  logic [31:0] sout_o;
  logic [1:0]  mode_o;
  logic        op_o;
  logic        nat_o;
  logic [7:0]  tag_o;
  logic [27:0] sum_o;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  normalise_sum_iter #(.MAX_LSHIFT(MAXL), .EXP_MIN(-126)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .in_valid                   (in_valid),
    .in_ready                   (in_ready),
    .idle_AddState              (idle_in),
    .sout_AddState              (sout_in),
    .modeout_AddState           (mode_in),
    .operationout_AddState      (op_in),
    .NatLogFlagout_AddState     (nat_in),
    .sum_AddState               (sum_in),
    .InsTag_AddState            (tag_in),
    .out_valid                  (out_valid),
    .out_ready                  (out_ready),
    .idle_NormaliseSum          (idle_o),
    .sout_NormaliseSum          (sout_o),
    .modeout_NormaliseSum       (mode_o),
    .operationout_NormaliseSum  (op_o),
    .NatLogFlagout_NormaliseSum (nat_o),
    .InsTag_NormaliseSum        (tag_o),
    .sum_NormaliseSum           (sum_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: apply the normalisation rules to the whole operand at once.
  function automatic void model(input logic [27:0] s, input logic [7:0] e8, input logic [1:0] idl,
                                output logic [27:0] so, output logic [7:0] eo, output int k);
    int e;
    int lz;
    int tot;
    e  = int'($signed(e8));
    so = s;
    k  = 1;
    if (idl == 2'b10) begin
    end else if (s[27]) begin
      so = s >> 1;
`ifdef NORM_STICKY_EN
      so[0] = so[0] | s[0];
`endif
      e = (e + 1 > 127) ? 127 : e + 1;
    end else if (s == 0) begin
      e = -126;
    end else if (!s[26] && e > -126) begin
      lz = 0;
      while (s[26 - lz] == 1'b0) lz++;
      tot = (lz < e + 126) ? lz : e + 126;
      so  = s << tot;
      e   = e - tot;
      k   = (tot + MAXL - 1) / MAXL;
    end
    eo = e[7:0];
  endfunction

  task automatic do_op(input logic [27:0] s, input logic [7:0] e8, input logic [1:0] idl,
                       input int stall, input string nm);
    logic [27:0] xs;
    logic [7:0]  xe;
    int          xk;
    int          w;
    int          cyc;
    logic [31:0] so_in;
    logic [1:0]  m;
    logic        o;
    logic        n;
    logic [7:0]  t;
    so_in = {1'($urandom), e8, 23'($urandom)};
    m = 2'($urandom);
    o = 1'($urandom);
    n = 1'($urandom);
    t = 8'($urandom);
    model(s, e8, idl, xs, xe, xk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clock); #1; w++;
    end
    chk({nm, ".in_ready"}, in_ready, 1);
    idle_in = idl; sout_in = so_in; mode_in = m; op_in = o; nat_in = n;
    sum_in = s; tag_in = t; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clock); #1; cyc++;
    end while (!out_valid && cyc < 40);
    chk({nm, ".latency"}, cyc, xk);
    chk({nm, ".sum"}, sum_o, xs);
    chk({nm, ".sout"}, sout_o, {so_in[31], xe, so_in[22:0]});
    chk({nm, ".side"}, {idle_o, mode_o, op_o, nat_o, tag_o}, {idl, m, o, n, t});
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      chk({nm, ".stall_valid"}, {out_valid, in_ready}, 2'b10);
      chk({nm, ".stall_sum"}, sum_o, xs);
    end
    chk({nm, ".hs_in_ready"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({nm, ".after_hs"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [27:0] rs;
    logic [7:0]  re;
    logic [1:0]  ri;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    idle_in = '0; sout_in = '0; mode_in = '0; op_in = 1'b0; nat_in = 1'b0;
    sum_in = '0; tag_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.sum", sum_o, 0);
    chk("rst.sout", sout_o, 0);
    chk("rst.side", {idle_o, mode_o, op_o, nat_o, tag_o}, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst.release_ready", in_ready, 1);

    do_op(28'h4000000, 8'd5, 2'b00, 0, "t1_norm");
    do_op(28'h8000001, 8'd3, 2'b01, 0, "t2_carry");
    do_op(28'h0000400, 8'd0, 2'b00, 0, "t3_lshift");
    do_op(28'h0000100, 8'(-120), 2'b00, 0, "t4_floor");
    do_op(28'h0000000, 8'd10, 2'b00, 0, "t5_zero");
    do_op(28'h0000400, 8'd10, 2'b10, 0, "t5_put");
    do_op(28'h8000000, 8'd127, 2'b00, 0, "t_expsat");
    do_op(28'h0000001, 8'd127, 2'b00, 0, "t_max_lz");
    do_op(28'h0000010, 8'(-128), 2'b00, 0, "t_below");
    do_op(28'h0001234, 8'd7, 2'b00, 5, "t6_stall");

    // Reset in NORM drops the operation.
    idle_in = 2'b00; sout_in = 32'h0000_0000; sum_in = 28'h0000400; tag_in = 8'h5a;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.in_ready", in_ready, 0);
    chk("midrst.sum", sum_o, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midrst.idle", {out_valid, in_ready}, 2'b01);

    for (int i = 0; i < 150; i++) begin
      rs = 28'($urandom) >> $urandom_range(0, 28);
      if ($urandom_range(0, 3) == 0) re = 8'(-128 + int'($urandom_range(0, 14)));
      else                           re = 8'($urandom);
      ri = 2'($urandom_range(0, 3));
      do_op(rs, re, ri, $urandom_range(0, 2), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
